// File: rtl/crgu_pwr_seq.sv
// crgu_pwr_seq: always-on power sequencer for the 13 MHz clock domain.
// It brings the domain up (OFF -> SETTLE -> HOLD -> RUN) and shuts it down
// (-> SHUT -> OFF), running entirely on the 32 kHz always-on clock.
//
// Ports
//   clk_32k         in   always-on 32 kHz clock
//   rst_32k_alon_n  in   async active-low reset, already synchronised upstream
//   rg_pwr_on       in   level request: 1 = bring domain to RUN, 0 = shut down
//   rg_settle_cyc   in   [7:0] minimum clk_32k cycles spent in SETTLE
//   rg_hold_cyc     in   [3:0] shut_rstn held low for rg_hold_cyc+1 cycles
//   ad_osc13m_rdy   in   oscillator ready (synchronised to clk_32k)
//   cmd_reset_32k   in   single-cycle soft reset of the domain (honoured in RUN)
//   osc13m_en       out  13 MHz oscillator enable
//   clk_en          out  6.5/13 MHz clock tree gate enable
//   shut_rstn       out  active-low reset of the shut-down domain
//   seq_state       out  [2:0] state: OFF=0 SETTLE=1 HOLD=2 RUN=3 SHUT=4
//   seq_done        out  one-cycle pulse on entry to RUN
//   seq_err         out  one-cycle pulse on settle watchdog timeout
//
// Build option: define CRGU_PWR_SEQ_WDT_EN to enable the SETTLE watchdog.
// Without it SETTLE waits indefinitely and seq_err is constant 0.
module crgu_pwr_seq (
  input  logic       clk_32k,
  input  logic       rst_32k_alon_n,
  input  logic       rg_pwr_on,
  input  logic [7:0] rg_settle_cyc,
  input  logic [3:0] rg_hold_cyc,
  input  logic       ad_osc13m_rdy,
  input  logic       cmd_reset_32k,
  output logic       osc13m_en,
  output logic       clk_en,
  output logic       shut_rstn,
  output logic [2:0] seq_state,
  output logic       seq_done,
  output logic       seq_err
);

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_SETTLE = 3'd1,
    ST_HOLD   = 3'd2,
    ST_RUN    = 3'd3,
    ST_SHUT   = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] cnt_inc;
  logic       osc_d, clken_d, rstn_d, done_d;
  logic       rearm_blk;

`ifdef CRGU_PWR_SEQ_WDT_EN
  logic lock_q, lock_d;
  logic err_d;
  assign rearm_blk = lock_q;
`else
  assign rearm_blk = 1'b0;
`endif

  // Saturating increment: a long SETTLE must never wrap back below the threshold.
  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef CRGU_PWR_SEQ_WDT_EN
    err_d   = 1'b0;
    lock_d  = lock_q;
    // Re-arm after a timeout only once the request has been seen low.
    if (!rg_pwr_on) lock_d = 1'b0;
`endif
    case (state_q)
      ST_OFF: begin
        if (rg_pwr_on && !rearm_blk) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
      end
      ST_SETTLE: begin
        if (!rg_pwr_on) begin
          state_d = ST_SHUT;
          cnt_d   = '0;
        end else if ((cnt_q >= rg_settle_cyc) && ad_osc13m_rdy) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
`ifdef CRGU_PWR_SEQ_WDT_EN
        end else if ((cnt_q == 8'hFF) && !ad_osc13m_rdy) begin
          state_d = ST_OFF;
          cnt_d   = '0;
          err_d   = 1'b1;
          lock_d  = 1'b1;
`endif
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_HOLD: begin
        if (!rg_pwr_on) begin
          state_d = ST_SHUT;
          cnt_d   = '0;
        end else if (cnt_q >= {4'b0000, rg_hold_cyc}) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RUN: begin
        // Power-off wins over a simultaneous soft reset.
        if (!rg_pwr_on) begin
          state_d = ST_SHUT;
          cnt_d   = '0;
        end else if (cmd_reset_32k) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_SHUT: begin
        // Two cycles with reset asserted and clocks still running.
        if (cnt_q != 8'd0) begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decoded from the next state so the registered values line up
  // with seq_state in the same cycle.
  always_comb begin
    osc_d   = 1'b0;
    clken_d = 1'b0;
    rstn_d  = 1'b0;
    case (state_d)
      ST_SETTLE: osc_d = 1'b1;
      ST_HOLD,
      ST_SHUT: begin
        osc_d   = 1'b1;
        clken_d = 1'b1;
      end
      ST_RUN: begin
        osc_d   = 1'b1;
        clken_d = 1'b1;
        rstn_d  = 1'b1;
      end
      default: ;
    endcase
    done_d = (state_d == ST_RUN) && (state_q != ST_RUN);
  end

  always_ff @(posedge clk_32k or negedge rst_32k_alon_n) begin
    if (!rst_32k_alon_n) begin
      state_q   <= ST_OFF;
      cnt_q     <= '0;
      osc13m_en <= 1'b0;
      clk_en    <= 1'b0;
      shut_rstn <= 1'b0;
      seq_done  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      osc13m_en <= osc_d;
      clk_en    <= clken_d;
      shut_rstn <= rstn_d;
      seq_done  <= done_d;
    end
  end

`ifdef CRGU_PWR_SEQ_WDT_EN
  always_ff @(posedge clk_32k or negedge rst_32k_alon_n) begin
    if (!rst_32k_alon_n) begin
      lock_q  <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      lock_q  <= lock_d;
      seq_err <= err_d;
    end
  end
`else
  assign seq_err = 1'b0;
`endif

  assign seq_state = state_q;

endmodule

// File: tb/tb_crgu_pwr_seq.sv
// Testbench for crgu_pwr_seq. Each stimulus cycle pushes the expected output
// vector {seq_state, osc13m_en, clk_en, shut_rstn, seq_done, seq_err} into a
// scoreboard queue; the entry is popped and compared one cycle later.
// Watchdog scenario follows CRGU_PWR_SEQ_WDT_EN.
module tb_crgu_pwr_seq;

  typedef enum logic [2:0] {
    S_OFF = 3'd0, S_SETTLE = 3'd1, S_HOLD = 3'd2, S_RUN = 3'd3, S_SHUT = 3'd4
  } st_e;

  logic       clk_32k = 1'b0;
  logic       rst_32k_alon_n;
  logic       rg_pwr_on;
  logic [7:0] rg_settle_cyc;
  logic [3:0] rg_hold_cyc;
  logic       ad_osc13m_rdy;
  logic       cmd_reset_32k;
  logic       osc13m_en, clk_en, shut_rstn, seq_done, seq_err;
  logic [2:0] seq_state;
  logic [7:0] act_vec;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  crgu_pwr_seq dut (
    .clk_32k        (clk_32k),
    .rst_32k_alon_n (rst_32k_alon_n),
    .rg_pwr_on      (rg_pwr_on),
    .rg_settle_cyc  (rg_settle_cyc),
    .rg_hold_cyc    (rg_hold_cyc),
    .ad_osc13m_rdy  (ad_osc13m_rdy),
    .cmd_reset_32k  (cmd_reset_32k),
    .osc13m_en      (osc13m_en),
    .clk_en         (clk_en),
    .shut_rstn      (shut_rstn),
    .seq_state      (seq_state),
    .seq_done       (seq_done),
    .seq_err        (seq_err)
  );

  always #5 clk_32k = ~clk_32k;

  assign act_vec = {seq_state, osc13m_en, clk_en, shut_rstn, seq_done, seq_err};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // osc13m_en/clk_en/shut_rstn per state.
  function automatic logic [7:0] exp_vec(input logic [2:0] st, input logic done, input logic err);
    logic [2:0] o;
    case (st)
      3'd1:    o = 3'b100;
      3'd2:    o = 3'b110;
      3'd3:    o = 3'b111;
      3'd4:    o = 3'b110;
      default: o = 3'b000;
    endcase
    return {st, o, done, err};
  endfunction

  task automatic step(input string tag, input logic pwr, input logic cmd, input logic rdy,
                      input logic [2:0] st, input logic done, input logic err);
    logic [7:0] e;
    rg_pwr_on     = pwr;
    cmd_reset_32k = cmd;
    ad_osc13m_rdy = rdy;
    exp_q.push_back(exp_vec(st, done, err));
    @(posedge clk_32k);
    #1;
    e = exp_q.pop_front();
    check(tag, {24'd0, act_vec}, {24'd0, e});
  endtask

  // With settle=4/hold=2: 5 SETTLE cycles, 3 HOLD cycles, RUN with done.
  // cmd_reset_32k pulses inside SETTLE and HOLD must be ignored.
  task automatic run_up(input string tag);
    step({tag, "_set0"}, 1'b1, 1'b0, 1'b1, S_SETTLE, 1'b0, 1'b0);
    step({tag, "_set1"}, 1'b1, 1'b1, 1'b1, S_SETTLE, 1'b0, 1'b0);
    for (int i = 2; i < 5; i++)
      step({tag, "_set"}, 1'b1, 1'b0, 1'b1, S_SETTLE, 1'b0, 1'b0);
    step({tag, "_hld0"}, 1'b1, 1'b0, 1'b1, S_HOLD, 1'b0, 1'b0);
    step({tag, "_hld1"}, 1'b1, 1'b1, 1'b1, S_HOLD, 1'b0, 1'b0);
    step({tag, "_hld2"}, 1'b1, 1'b0, 1'b1, S_HOLD, 1'b0, 1'b0);
    step({tag, "_run"},  1'b1, 1'b0, 1'b1, S_RUN,  1'b1, 1'b0);
  endtask

  task automatic shut_down(input string tag, input logic cmd);
    step({tag, "_shut0"}, 1'b0, cmd,  1'b1, S_SHUT, 1'b0, 1'b0);
    step({tag, "_shut1"}, 1'b0, 1'b0, 1'b1, S_SHUT, 1'b0, 1'b0);
    step({tag, "_off"},   1'b0, 1'b0, 1'b1, S_OFF,  1'b0, 1'b0);
  endtask

  initial begin
    rg_pwr_on      = 1'b0;
    rg_settle_cyc  = 8'd4;
    rg_hold_cyc    = 4'd2;
    ad_osc13m_rdy  = 1'b1;
    cmd_reset_32k  = 1'b0;
    rst_32k_alon_n = 1'b1;
    #1 rst_32k_alon_n = 1'b0;
    #1 check("reset_async", {24'd0, act_vec}, 32'd0);
    @(posedge clk_32k);
    #1 check("reset_held", {24'd0, act_vec}, 32'd0);
    rst_32k_alon_n = 1'b1;

    step("off_idle", 1'b0, 1'b0, 1'b1, S_OFF, 1'b0, 1'b0);
    run_up("up1");
    step("run_stay", 1'b1, 1'b0, 1'b1, S_RUN, 1'b0, 1'b0);

    // Soft reset in RUN: 3 HOLD cycles with clocks on, then RUN with a new done.
    step("rerst_h0", 1'b1, 1'b1, 1'b1, S_HOLD, 1'b0, 1'b0);
    step("rerst_h1", 1'b1, 1'b0, 1'b1, S_HOLD, 1'b0, 1'b0);
    step("rerst_h2", 1'b1, 1'b0, 1'b1, S_HOLD, 1'b0, 1'b0);
    step("rerst_run", 1'b1, 1'b0, 1'b1, S_RUN, 1'b1, 1'b0);
    step("rerst_stay", 1'b1, 1'b0, 1'b1, S_RUN, 1'b0, 1'b0);

    shut_down("dn1", 1'b0);
    step("off_stay", 1'b0, 1'b1, 1'b1, S_OFF, 1'b0, 1'b0);

    // Power-off while in HOLD.
    for (int i = 0; i < 5; i++)
      step("up2_set", 1'b1, 1'b0, 1'b1, S_SETTLE, 1'b0, 1'b0);
    step("up2_hld", 1'b1, 1'b0, 1'b1, S_HOLD, 1'b0, 1'b0);
    shut_down("dn_hold", 1'b0);

    // Power-off and soft reset in the same RUN cycle.
    run_up("up3");
    shut_down("dn_prio", 1'b1);

    // Oscillator never ready; settle threshold raised mid-SETTLE.
    step("slow_set0", 1'b1, 1'b0, 1'b0, S_SETTLE, 1'b0, 1'b0);
`ifdef CRGU_PWR_SEQ_WDT_EN
    for (int i = 0; i < 255; i++) begin
      if (i == 10) rg_settle_cyc = 8'd200;
      step("wdt_set", 1'b1, 1'b0, 1'b0, S_SETTLE, 1'b0, 1'b0);
    end
    step("wdt_err",    1'b1, 1'b0, 1'b0, S_OFF,    1'b0, 1'b1);
    step("wdt_lock",   1'b1, 1'b0, 1'b1, S_OFF,    1'b0, 1'b0);
    step("wdt_clear",  1'b0, 1'b0, 1'b1, S_OFF,    1'b0, 1'b0);
    step("wdt_rearm",  1'b1, 1'b0, 1'b1, S_SETTLE, 1'b0, 1'b0);
    shut_down("dn_wdt", 1'b0);
`else
    for (int i = 0; i < 299; i++) begin
      if (i == 10) rg_settle_cyc = 8'd200;
      step("slow_set", 1'b1, 1'b0, 1'b0, S_SETTLE, 1'b0, 1'b0);
    end
    // Counter saturated at 255 >= 200, so ready gives HOLD at once.
    step("slow_hld", 1'b1, 1'b0, 1'b1, S_HOLD, 1'b0, 1'b0);
    shut_down("dn_slow", 1'b0);
`endif
    rg_settle_cyc = 8'd4;

    // Asynchronous reset mid-HOLD, then a clean restart.
    for (int i = 0; i < 5; i++)
      step("up4_set", 1'b1, 1'b0, 1'b1, S_SETTLE, 1'b0, 1'b0);
    step("up4_hld", 1'b1, 1'b0, 1'b1, S_HOLD, 1'b0, 1'b0);
    #2 rst_32k_alon_n = 1'b0;
    #1 check("rst_mid_hold", {24'd0, act_vec}, 32'd0);
    @(posedge clk_32k);
    #1 check("rst_mid_held", {24'd0, act_vec}, 32'd0);
    rst_32k_alon_n = 1'b1;
    run_up("up5");
    step("up5_stay", 1'b1, 1'b0, 1'b1, S_RUN, 1'b0, 1'b0);
    shut_down("dn5", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
